// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, requests to send, shifts out
// one command byte with odd parity on device clock falls, then samples the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, DONE} state_t;

  state_t        state;
  logic [8:0]    sh;
  logic [3:0]    bitcnt;
  logic [CW-1:0] cnt;
  logic          clk_meta, clk_sync, clk_prev;
  logic          data_meta, data_sync;
  logic          fall;
  logic          wd_expired;

  // Synchronisers preset to the idle-high line level so reset never fakes a fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= ps2_clk_in;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data_in;
      data_sync <= data_meta;
    end
  end

  assign fall       = clk_prev & ~clk_sync;
  assign wd_expired = (cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sh          <= '0;
      bitcnt      <= '0;
      cnt         <= '0;
      tx_ready    <= 1'b1;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      busy        <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx_err <= 1'b0;
          if (tx_valid && tx_ready) begin
            sh          <= {~^tx_data, tx_data};
            bitcnt      <= '0;
            cnt         <= '0;
            state       <= INHIBIT;
            tx_ready    <= 1'b0;
            busy        <= 1'b1;
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= 1'b0;
          end
        end
        INHIBIT: begin
          if (cnt == INH_LAST) begin
            cnt         <= '0;
            state       <= RTS;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RTS, SEND, ACK: begin
          // Watchdog is checked before the fall so a simultaneous expiry wins.
          if (wd_expired) begin
            state       <= IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b1;
            tx_err      <= 1'b1;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
            if (fall) begin
              if (state == RTS) begin
                ps2_data_oe <= ~sh[0];
                sh          <= {1'b0, sh[8:1]};
                bitcnt      <= 4'd1;
                state       <= SEND;
              end else if (state == SEND) begin
                if (bitcnt < 4'd9) begin
                  ps2_data_oe <= ~sh[0];
                  sh          <= {1'b0, sh[8:1]};
                  bitcnt      <= bitcnt + 1'b1;
                end else begin
                  ps2_data_oe <= 1'b0;
                  state       <= ACK;
                end
              end else begin
                state       <= DONE;
                tx_done     <= 1'b1;
                tx_err      <= data_sync;
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
              end
            end
          end
        end
        DONE: begin
          if (clk_sync && data_sync) begin
            state    <= IDLE;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            tx_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: PS/2 device model with a 40-cycle clock, frame scoreboard and per-cycle output monitor.
module tb_ps2_host_tx;

  localparam int INH = 50;
  localparam int TO  = 20000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err, busy, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic       ps2_clk_in, ps2_data_in;

  // Open-drain wiring of host and device.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err), .busy(busy),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0;
  logic [7:0] acc_q[$];
  int         kind_q[$];   // 0 = ACK, 1 = NACK, 2 = timeout
  bit         mon_en = 0;
  int         done_cnt = 0, accepts = 0;

  task automatic check_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0);
    return {1'b1, par, b};
  endfunction

  // Monitor: handshake latency, invariants, inhibit length, done/err against expectations.
  bit         pend = 0, prev_done = 0, wait_idle = 0, ready_next = 0;
  logic [7:0] pend_byte;
  int         inh_len = 0, rts_cyc = 0, mon_k;
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (pend) begin
        check_eq("accept_latency", {ps2_clk_oe, tx_ready, busy}, 3'b101);
        acc_q.push_back(pend_byte);
        accepts++;
      end
      pend      = tx_valid && tx_ready && !rst;
      pend_byte = tx_data;
      check_eq("invariant", {busy == tx_ready, ps2_clk_oe && ps2_data_oe,
                             tx_ready && (ps2_clk_oe || ps2_data_oe)}, 3'b000);
      if (prev_done) check_eq("done_width", tx_done, 0);
      if (ready_next) begin
        check_eq("timeout_ready_next", tx_ready, 1);
        ready_next = 0;
      end
      if (ps2_clk_oe) inh_len++;
      else if (inh_len > 0) begin
        check_eq("inhibit_len", inh_len, INH);
        inh_len = 0;
        rts_cyc = cyc;
      end
      if (wait_idle && !busy) begin
        check_eq("idle_lines_at_busy_drop", {ps2_clk_in, ps2_data_in}, 2'b11);
        wait_idle = 0;
      end
      if (tx_done && !prev_done) begin
        done_cnt++;
        if (kind_q.size() == 0) check_eq("unexpected_done", 1, 0);
        else begin
          mon_k = kind_q.pop_front();
          check_eq("tx_err", tx_err, (mon_k != 0));
          check_eq("done_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
          if (mon_k == 2) begin
            check_eq("timeout_len", cyc - rts_cyc, TO);
            if (acc_q.size() > 0) void'(acc_q.pop_front());
            ready_next = 1;
          end else begin
            wait_idle = 1;
          end
        end
      end
      prev_done = tx_done;
    end
  end

  // Device: waits for request-to-send, generates npulse clocks, samples on rising edges.
  task automatic dev_xfer(input int npulse, input bit nack, output logic [9:0] bits);
    int t = 0;
    logic [7:0] eb;
    bits = '0;
    while (!(ps2_clk_in && !ps2_data_in) && t < 5000) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 5000) begin
      check_eq("rts_wait_timeout", t, 0);
      return;
    end
    repeat (10) @(posedge clk);
    for (int i = 0; i < npulse; i++) begin
      repeat (10) @(posedge clk);
      #1;
      if (i == 10) begin
        kind_q.push_back(nack ? 1 : 0);
        dev_data_low = !nack;
      end
      repeat (10) @(posedge clk);
      #1 dev_clk_low = 1'b1;
      repeat (20) @(posedge clk);
      #1 dev_clk_low = 1'b0;
      if (i < 10) bits[i] = ps2_data_in;
    end
    if (npulse == 11) begin
      repeat (30) @(posedge clk);
      #1 dev_data_low = 1'b0;
      if (acc_q.size() == 0) check_eq("frame_without_accept", 1, 0);
      else begin
        eb = acc_q.pop_front();
        check_eq("frame_bits", bits, frame_of(eb));
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    @(posedge clk); #1;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 2000) check_eq("send_ready_timeout", t, 0);
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_ready(input int limit);
    int t = 0;
    while (!tx_ready && t < limit) begin
      @(posedge clk); #1; t++;
    end
    if (t >= limit) check_eq("ready_timeout", t, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  logic [9:0] bits, bits1, bits2;
  int         dc, acc0;
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx_ready", tx_ready, 1);
    check_eq("rst_tx_done", tx_done, 0);
    check_eq("rst_tx_err", tx_err, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    rst    = 1'b0;
    mon_en = 1;

    send(8'hF4);
    dev_xfer(11, 0, bits);
    check_eq("f4_bits", bits, 10'h2F4);
    wait_ready(500);

    send(8'hFF);
    dev_xfer(11, 1, bits);
    check_eq("ff_bits", bits, 10'h3FF);
    wait_ready(500);

    kind_q.push_back(2);
    send(8'h5A);
    wait_ready(TO + 500);
    repeat (3) @(posedge clk);

    // Held valid: one 0x00 frame, then 0xAA only once ready returns.
    acc0 = accepts;
    @(posedge clk); #1;
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    fork
      dev_xfer(11, 0, bits1);
      begin
        repeat (200) @(posedge clk);
        #1 tx_data = 8'hAA;
      end
    join
    wait_ready(500);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    dev_xfer(11, 0, bits2);
    check_eq("hold_frame0_bits", bits1, 10'h300);
    check_eq("hold_frame1_bits", bits2, 10'h3AA);
    wait_ready(500);
    check_eq("hold_accepts", accepts - acc0, 2);

    // Reset in the middle of SEND.
    dc = done_cnt;
    send(8'h96);
    dev_xfer(5, 0, bits);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("mid_reset_outputs", {ps2_clk_oe, ps2_data_oe, tx_ready, busy, tx_done}, 5'b00100);
    acc_q.delete();
    repeat (100) @(posedge clk);
    check_eq("no_done_after_reset", done_cnt, dc);

    send(8'hF3);
    dev_xfer(11, 0, bits);
    check_eq("f3_bits", bits, 10'h3F3);
    wait_ready(500);

    for (int n = 0; n < 8; n++) begin
      logic [7:0] rb;
      bit         rn;
      rb = 8'($urandom);
      rn = 1'($urandom % 2);
      repeat ($urandom_range(0, 30)) @(posedge clk);
      send(rb);
      dev_xfer(11, rn, bits);
      wait_ready(500);
    end

    repeat (5) @(posedge clk);
    check_eq("acc_q_empty", acc_q.size(), 0);
    check_eq("kind_q_empty", kind_q.size(), 0);
    check_eq("done_total", done_cnt, 14);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
